// File: rtl/slot_fifo.sv
// slot_fifo: first-word-fall-through FIFO feeding the grouping/aggregation stages.
// Head word is a combinational read of the slot under the read pointer.
module slot_fifo #(
  parameter int NUM_SLOTS     = 4,
  parameter int LOG_NUM_SLOTS = 2,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_write,
  input  logic                  write,
  output logic                  full,
  output logic                  almost_full,
  output logic [DATA_WIDTH-1:0] data_read,
  input  logic                  next_read,
  output logic                  empty
);

  localparam int CW = LOG_NUM_SLOTS + 1;

  localparam logic [CW-1:0] CNT_FULL =
    CW'(NUM_SLOTS);
  localparam logic [CW-1:0] CNT_AFULL =
    CW'(NUM_SLOTS - 1);
  localparam logic [LOG_NUM_SLOTS-1:0] PTR_LAST =
    LOG_NUM_SLOTS'(NUM_SLOTS - 1);

  logic [DATA_WIDTH-1:0]    mem [NUM_SLOTS];
  logic [LOG_NUM_SLOTS-1:0] wr_ptr;
  logic [LOG_NUM_SLOTS-1:0] rd_ptr;
  logic [CW-1:0]            count;

  logic                     do_write;
  logic                     do_read;
  logic [LOG_NUM_SLOTS-1:0] wr_ptr_nxt;
  logic [LOG_NUM_SLOTS-1:0] rd_ptr_nxt;
  logic [CW-1:0]            count_nxt;

  assign empty       = (count == '0);
  assign full        = (count == CNT_FULL);
  assign almost_full = (count == CNT_AFULL);
  assign data_read   = mem[rd_ptr];

  // Full drops writes even alongside a read; empty ignores reads.
  assign do_write = write & ~full;
  assign do_read  = next_read & ~empty;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    if (do_write) begin
      if (wr_ptr == PTR_LAST)
        wr_ptr_nxt = '0;
      else
        wr_ptr_nxt = wr_ptr + 1'b1;
    end
  end

  always_comb begin
    rd_ptr_nxt = rd_ptr;
    if (do_read) begin
      if (rd_ptr == PTR_LAST)
        rd_ptr_nxt = '0;
      else
        rd_ptr_nxt = rd_ptr + 1'b1;
    end
  end

  always_comb begin
    count_nxt = count;
    unique case ({do_write, do_read})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SLOTS; i++)
        mem[i] <= '0;
    end else if (do_write) begin
      mem[wr_ptr] <= data_write;
    end
  end

endmodule

// File: tb/tb_slot_fifo.sv
// tb_slot_fifo: directed tests for slot_fifo.
// Each task drives its scenario and checks results inline.
module tb_slot_fifo;

  logic        clk;
  logic        rst;
  logic [31:0] data_write;
  logic        write;
  logic        full;
  logic        almost_full;
  logic [31:0] data_read;
  logic        next_read;
  logic        empty;

  int tests;
  int fails;

  slot_fifo #(
    .NUM_SLOTS(4),
    .LOG_NUM_SLOTS(2),
    .DATA_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_write(data_write),
    .write(write),
    .full(full),
    .almost_full(almost_full),
    .data_read(data_read),
    .next_read(next_read),
    .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    data_write = d;
    write      = 1'b1;
    next_read  = 1'b0;
    step();
    write      = 1'b0;
  endtask

  task automatic pop();
    write     = 1'b0;
    next_read = 1'b1;
    step();
    next_read = 1'b0;
  endtask

  task automatic both(input logic [31:0] d);
    data_write = d;
    write      = 1'b1;
    next_read  = 1'b1;
    step();
    write      = 1'b0;
    next_read  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    tests++;
    if ({empty, full, almost_full} !== 3'b100) begin
      fails++;
      $display("FAIL reset_flags got=%b exp=100",
               {empty, full, almost_full});
    end
    rst = 1'b1;
    step();
    push(32'h1);
    push(32'h2);
    push(32'h3);
    tests++;
    if (almost_full !== 1'b1 || data_read !== 32'h1) begin
      fails++;
      $display("FAIL pre_reset af=%b head=%h exp 1/1",
               almost_full, data_read);
    end
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if ({empty, full, almost_full} !== 3'b100) begin
      fails++;
      $display("FAIL midreset_flags got=%b exp=100",
               {empty, full, almost_full});
    end
    tests++;
    if (data_read !== 32'h0) begin
      fails++;
      $display("FAIL midreset_data got=%h exp=0", data_read);
    end
    step();
    rst = 1'b1;
    pop();
    tests++;
    if ({empty, full, almost_full} !== 3'b100 ||
        data_read !== 32'h0) begin
      fails++;
      $display("FAIL reset_pop flags=%b data=%h exp 100/0",
               {empty, full, almost_full}, data_read);
    end
  endtask

  task automatic test_fill();
    logic [31:0] v [4];
    logic [2:0]  exp_f [4];
    v[0] = 32'hA1; v[1] = 32'hA2;
    v[2] = 32'hA3; v[3] = 32'hA4;
    // {empty, full, almost_full} after each write
    exp_f[0] = 3'b000; exp_f[1] = 3'b000;
    exp_f[2] = 3'b001; exp_f[3] = 3'b010;
    for (int i = 0; i < 4; i++) begin
      push(v[i]);
      tests++;
      if ({empty, full, almost_full} !== exp_f[i] ||
          data_read !== 32'hA1) begin
        fails++;
        $display("FAIL fill_%0d flags=%b data=%h exp %b/a1",
                 i, {empty, full, almost_full}, data_read,
                 exp_f[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_d;
    push(32'hFF);
    tests++;
    if (full !== 1'b1 || data_read !== 32'hA1) begin
      fails++;
      $display("FAIL overflow_hold full=%b data=%h exp 1/a1",
               full, data_read);
    end
    for (int i = 0; i < 4; i++) begin
      exp_d = 32'hA1 + 32'(i);
      tests++;
      if (empty !== 1'b0 || data_read !== exp_d) begin
        fails++;
        $display("FAIL drain_%0d empty=%b data=%h exp 0/%h",
                 i, empty, data_read, exp_d);
      end
      pop();
    end
    tests++;
    if ({empty, full, almost_full} !== 3'b100) begin
      fails++;
      $display("FAIL drain_end flags=%b exp=100",
               {empty, full, almost_full});
    end
  endtask

  task automatic test_simultaneous();
    push(32'h10);
    push(32'h11);
    both(32'h12);
    tests++;
    if ({empty, full, almost_full} !== 3'b000 ||
        data_read !== 32'h11) begin
      fails++;
      $display("FAIL simul_mid flags=%b data=%h exp 000/11",
               {empty, full, almost_full}, data_read);
    end
    pop();
    tests++;
    if (empty !== 1'b0 || data_read !== 32'h12) begin
      fails++;
      $display("FAIL simul_next empty=%b data=%h exp 0/12",
               empty, data_read);
    end
    pop();
    tests++;
    if (empty !== 1'b1) begin
      fails++;
      $display("FAIL simul_end empty=%b exp=1", empty);
    end
  endtask

  task automatic test_full_both();
    push(32'h20);
    push(32'h21);
    push(32'h22);
    push(32'h23);
    both(32'h99);
    tests++;
    if ({empty, full, almost_full} !== 3'b001 ||
        data_read !== 32'h21) begin
      fails++;
      $display("FAIL fullboth flags=%b data=%h exp 001/21",
               {empty, full, almost_full}, data_read);
    end
    pop();
    pop();
    tests++;
    if (data_read !== 32'h23 || empty !== 1'b0) begin
      fails++;
      $display("FAIL fullboth_tail data=%h empty=%b exp 23/0",
               data_read, empty);
    end
    pop();
    tests++;
    if (empty !== 1'b1) begin
      fails++;
      $display("FAIL fullboth_end empty=%b exp=1", empty);
    end
  endtask

  task automatic test_empty_corner();
    both(32'h55);
    tests++;
    if (empty !== 1'b0 || data_read !== 32'h55 ||
        almost_full !== 1'b0) begin
      fails++;
      $display("FAIL empty_both empty=%b data=%h exp 0/55",
               empty, data_read);
    end
    pop();
    tests++;
    if (empty !== 1'b1) begin
      fails++;
      $display("FAIL empty_pop empty=%b exp=1", empty);
    end
    pop();
    tests++;
    if ({empty, full, almost_full} !== 3'b100) begin
      fails++;
      $display("FAIL empty_idle flags=%b exp=100",
               {empty, full, almost_full});
    end
  endtask

  task automatic test_wrap();
    int sent;
    int recv;
    int occ;
    int cyc;
    logic wr;
    logic rd;
    sent = 0;
    recv = 0;
    occ  = 0;
    cyc  = 0;
    while (recv < 20 && cyc < 300) begin
      wr = (sent < 20) && (occ < 3) && ((cyc % 3) != 2);
      rd = (occ >= 2) || (sent == 20 && occ > 0);
      if (rd) begin
        tests++;
        if (data_read !== 32'(recv)) begin
          fails++;
          $display("FAIL wrap_%0d data=%h exp=%h",
                   recv, data_read, 32'(recv));
        end
      end
      data_write = 32'(sent);
      write      = wr;
      next_read  = rd;
      step();
      write     = 1'b0;
      next_read = 1'b0;
      if (wr) begin
        sent++;
        occ++;
      end
      if (rd) begin
        recv++;
        occ--;
      end
      cyc++;
    end
    tests++;
    if (recv != 20 || empty !== 1'b1) begin
      fails++;
      $display("FAIL wrap_done recv=%0d empty=%b exp 20/1",
               recv, empty);
    end
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    rst        = 1'b0;
    write      = 1'b0;
    next_read  = 1'b0;
    data_write = '0;
    test_reset();
    test_fill();
    test_overflow();
    test_simultaneous();
    test_full_both();
    test_empty_corner();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
